jtag_shift_sequencer: RTL and testbench

JTAG_SHIFT_SEQUENCER -- requirements
Module: jtag_shift_sequencer

---
 rtl/jtag_shift_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_jtag_shift_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_shift_sequencer.sv
// Purpose : runs one IR or DR scan of 1..32 bits on a JTAG TAP per command and returns the captured TDO bits.
// Latency : (len+5) TCK periods for DR, (len+6) for IR, each 2*TCK_HALF sysclk cycles; rsp_valid the cycle after.
// Backpressure: one scan in flight; cmd_ready stays low until the response has been taken with rsp_ready.
//
// Ports:
//   sysclk, sys_reset          system clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake; cmd_ir (1 = IR scan), cmd_len (0 = 32 bits), cmd_data (LSB first)
//   rsp_valid/rsp_ready        response handshake; rsp_data bit i = i-th TDO bit, unused upper bits zero
//   tck, tms, tdi, tdo         TAP pins
//   busy                       high whenever the sequencer is not idle
// Build option: define JTAG_SEQ_INIT_TLR_EN to walk the TAP through Test-Logic-Reset into
// Run-Test/Idle after every reset; otherwise the TAP is assumed reset externally.
module jtag_shift_sequencer #(
   parameter int unsigned TCK_HALF = 2
) (
   input  logic        sysclk,
   input  logic        sys_reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_ir,
   input  logic [4:0]  cmd_len,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        tck,
   output logic        tms,
   output logic        tdi,
   input  logic        tdo,
   output logic        busy
);

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_ENTER = 3'd2,
      ST_SHIFT = 3'd3,
      ST_EXIT  = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [7:0] HALF_LAST = 8'(TCK_HALF - 1);

   state_t      state, state_nxt;
   logic [5:0]  step_cnt, step_nxt;   // TCK period index within the current state
   logic [7:0]  half_cnt;             // sysclk cycles elapsed in the current TCK half
   logic        tck_active;
   logic        half_end;
   logic        period_end;
   logic        cmd_free;
   logic        accept;
   logic        rst_hold;
   logic        tms_nxt;
   logic        tdi_nxt;

   logic        ir_q;
   logic [5:0]  len_q;                // 1..32, so the last bit is a plain compare
   logic [31:0] data_q;

   // Without the TLR walk there is no INIT state; rst_hold keeps busy high and
   // cmd_ready low for the reset cycles themselves.
`ifdef JTAG_SEQ_INIT_TLR_EN
   assign rst_hold = 1'b0;
`else
   always_ff @(posedge sysclk) begin
      rst_hold <= sys_reset;
   end
`endif

   assign tck_active = (state == ST_INIT) || (state == ST_ENTER) ||
                       (state == ST_SHIFT) || (state == ST_EXIT);
   assign half_end   = tck_active && (half_cnt == HALF_LAST);
   // A period ends as its high half ends; this edge also starts the next low half.
   assign period_end = half_end && tck;
   assign cmd_free   = (state == ST_IDLE) && !rsp_valid && !rst_hold;
   assign accept     = cmd_valid && cmd_free;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge sysclk) begin
      if (sys_reset) begin
`ifdef JTAG_SEQ_INIT_TLR_EN
         state <= ST_INIT;
`else
         state <= ST_IDLE;
`endif
         step_cnt <= '0;
      end else begin
         state    <= state_nxt;
         step_cnt <= step_nxt;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_nxt = state;
      step_nxt  = step_cnt;
      case (state)
`ifdef JTAG_SEQ_INIT_TLR_EN
         ST_INIT: begin
            if (period_end) begin
               if (step_cnt == 6'd5) begin
                  state_nxt = ST_IDLE;
                  step_nxt  = '0;
               end else begin
                  step_nxt = step_cnt + 6'd1;
               end
            end
         end
`endif
         ST_IDLE: begin
            if (accept) begin
               state_nxt = ST_ENTER;
               step_nxt  = '0;
            end
         end
         ST_ENTER: begin
            if (period_end) begin
               if (step_cnt == (ir_q ? 6'd3 : 6'd2)) begin
                  state_nxt = ST_SHIFT;
                  step_nxt  = '0;
               end else begin
                  step_nxt = step_cnt + 6'd1;
               end
            end
         end
         ST_SHIFT: begin
            if (period_end) begin
               if (step_cnt == len_q - 6'd1) begin
                  state_nxt = ST_EXIT;
                  step_nxt  = '0;
               end else begin
                  step_nxt = step_cnt + 6'd1;
               end
            end
         end
         ST_EXIT: begin
            if (period_end) begin
               if (step_cnt == 6'd1) begin
                  state_nxt = ST_DONE;
                  step_nxt  = '0;
               end else begin
                  step_nxt = step_cnt + 6'd1;
               end
            end
         end
         ST_DONE: begin
            if (rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            step_nxt  = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   // tms/tdi are looked up for the period about to start and registered, so the
   // TAP pins only move on the first sysclk cycle of a low half.
   always_comb begin
      cmd_ready = cmd_free;
      busy      = (state != ST_IDLE) || rst_hold;
      tms_nxt   = 1'b0;
      tdi_nxt   = 1'b0;
      case (state_nxt)
         ST_INIT:  tms_nxt = (step_nxt < 6'd5);
         ST_ENTER: tms_nxt = ir_q ? (step_nxt < 6'd2) : (step_nxt == 6'd0);
         ST_SHIFT: begin
            tms_nxt = (step_nxt == len_q - 6'd1);
            tdi_nxt = data_q[step_nxt[4:0]];
         end
         ST_EXIT:  tms_nxt = (step_nxt == 6'd0);
         default:  ;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge sysclk) begin
      if (sys_reset) begin
         half_cnt  <= '0;
         tck       <= 1'b0;
         tms       <= 1'b1;
         tdi       <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         ir_q      <= 1'b0;
         len_q     <= '0;
         data_q    <= '0;
      end else begin
         if (half_end) begin
            half_cnt <= '0;
            tck      <= ~tck;
         end else if (tck_active) begin
            half_cnt <= half_cnt + 8'd1;
         end else begin
            half_cnt <= '0;
            tck      <= 1'b0;
         end

         // ENTER step 0 is tms=1 for both scan types, so ir_q not yet being
         // latched on the accept edge does not matter.
         if (period_end || accept) begin
            tms <= tms_nxt;
            tdi <= tdi_nxt;
         end

         if (accept) begin
            ir_q     <= cmd_ir;
            len_q    <= (cmd_len == 5'd0) ? 6'd32 : {1'b0, cmd_len};
            data_q   <= cmd_data;
            rsp_data <= '0;
         end

         // tdo is taken on the last sysclk cycle of the high half.
         if (period_end && (state == ST_SHIFT)) begin
            rsp_data[step_cnt[4:0]] <= tdo;
         end

         if (period_end && (state == ST_EXIT) && (step_cnt == 6'd1)) begin
            rsp_valid <= 1'b1;
         end else if ((state == ST_DONE) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_jtag_shift_sequencer.sv
module tb_jtag_shift_sequencer;

   localparam int TCK_HALF = 2;
   localparam int M_BYP  = 0;   // 1-bit bypass register between tdi and tdo
   localparam int M_ONE  = 1;   // tdo tied high
   localparam int M_LOOP = 2;   // tdo wired straight to tdi

   typedef struct packed {
      logic        ir;
      logic [4:0]  len;
      logic [31:0] data;
      int          mode;
      logic [31:0] exp_rsp;
      int          exp_periods;
      logic [63:0] exp_tms;      // bit k = tms during TCK period k
   } vec_t;

   logic        sysclk    = 1'b0;
   logic        sys_reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_ir    = 1'b0;
   logic [4:0]  cmd_len   = 5'd0;
   logic [31:0] cmd_data  = 32'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        tck, tms, tdi, tdo, busy;

   int   tdo_mode = M_BYP;
   logic byp_q    = 1'b0;
   logic tdo_q    = 1'b0;

   int   rise_cnt = 0;
   logic tms_hist [0:4095];
   logic tdi_hist [0:4095];

   int   n_checks = 0;
   int   n_fail   = 0;
   int   mon_bad  = 0;
   int   hi_run   = 0;
   logic prev_tck = 1'b0;
   logic prev_tms = 1'b1;
   logic prev_tdi = 1'b0;

   vec_t vecs [0:6];

   always #5 sysclk = ~sysclk;

   jtag_shift_sequencer #(.TCK_HALF(TCK_HALF)) dut (
      .sysclk    (sysclk),
      .sys_reset (sys_reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_ir    (cmd_ir),
      .cmd_len   (cmd_len),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .tck       (tck),
      .tms       (tms),
      .tdi       (tdi),
      .tdo       (tdo),
      .busy      (busy)
   );

   // TAP model: log pins on each rising TCK; bypass captures on rise, drives tdo on fall.
   always @(posedge tck) begin
      if (rise_cnt < 4096) begin
         tms_hist[rise_cnt] = tms;
         tdi_hist[rise_cnt] = tdi;
      end
      rise_cnt = rise_cnt + 1;
      byp_q <= tdi;
   end

   always @(negedge tck) tdo_q <= byp_q;

   assign tdo = (tdo_mode == M_LOOP) ? tdi : ((tdo_mode == M_ONE) ? 1'b1 : tdo_q);

   // TCK shape: every high half lasts TCK_HALF cycles, tms/tdi steady while tck is high.
   always @(posedge sysclk) begin
      if (sys_reset) begin
         hi_run = 0;
      end else begin
         if (tck) begin
            hi_run = hi_run + 1;
         end else if (hi_run != 0) begin
            if (hi_run != TCK_HALF) mon_bad = mon_bad + 1;
            hi_run = 0;
         end
         if (tck && prev_tck && ((tms !== prev_tms) || (tdi !== prev_tdi))) mon_bad = mon_bad + 1;
      end
      prev_tck = tck;
      prev_tms = tms;
      prev_tdi = tdi;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Called at a negedge with sys_reset high; releases it and times the way to IDLE.
   task automatic check_init(input string tag);
      int          cyc;
      int          base;
      logic [63:0] tv;
      base = rise_cnt;
      cyc  = 0;
      sys_reset = 1'b0;
      while (cyc < 200 && cmd_ready !== 1'b1) begin
         @(negedge sysclk);
         cyc = cyc + 1;
      end
`ifdef JTAG_SEQ_INIT_TLR_EN
      check({tag, "_init_cycles"}, cyc, 12 * TCK_HALF);
      check({tag, "_init_periods"}, rise_cnt - base, 6);
      tv = '0;
      for (int k = 0; k < 6; k++) tv[k] = tms_hist[base + k];
      check({tag, "_init_tms"}, tv, 64'h1F);
`else
      check({tag, "_idle_cycles"}, cyc, 1);
      check({tag, "_init_periods"}, rise_cnt - base, 0);
`endif
      check({tag, "_idle_busy"}, busy, 0);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int          base;
      int          cyc;
      int          periods;
      logic [63:0] tms_v;
      logic [63:0] tdi_v;
      logic [63:0] mask;
      logic [63:0] exp_tdi;
      tdo_mode  = v.mode;
      cmd_ir    = v.ir;
      cmd_len   = v.len;
      cmd_data  = v.data;
      cmd_valid = 1'b1;
      cyc = 0;
      while (cyc < 50 && cmd_ready !== 1'b1) begin
         @(negedge sysclk);
         cyc = cyc + 1;
      end
      check({tag, "_accept"}, cmd_ready, 1);
      base = rise_cnt;
      @(negedge sysclk);
      cmd_valid = 1'b0;
      cmd_data  = 32'h0;
      cyc = 0;
      while (cyc < 5000 && rsp_valid !== 1'b1) begin
         @(negedge sysclk);
         cyc = cyc + 1;
      end
      check({tag, "_rsp_valid"}, rsp_valid, 1);
      periods = rise_cnt - base;
      check({tag, "_periods"}, periods, v.exp_periods);
      check({tag, "_rsp_data"}, rsp_data, v.exp_rsp);
      tms_v = '0;
      tdi_v = '0;
      for (int k = 0; k < 64; k++) begin
         if (k < periods) begin
            tms_v[k] = tms_hist[base + k];
            tdi_v[k] = tdi_hist[base + k];
         end
      end
      mask    = (v.len == 5'd0) ? 64'hFFFF_FFFF : ((64'd1 << v.len) - 64'd1);
      exp_tdi = ({32'h0, v.data} & mask) << (v.ir ? 4 : 3);
      check({tag, "_tms_seq"}, tms_v, v.exp_tms);
      check({tag, "_tdi_seq"}, tdi_v, exp_tdi);
      rsp_ready = 1'b1;
      @(negedge sysclk);
      rsp_ready = 1'b0;
      check({tag, "_rsp_drop"}, rsp_valid, 0);
   endtask

   initial begin
      int base;
      int cyc;
      int bad;

      vecs[0] = '{1'b0, 5'd8,  32'h0000_00A5, M_BYP,  32'h0000_004A, 13, 64'h0000_0000_0000_0C01};
      vecs[1] = '{1'b1, 5'd5,  32'h0000_001F, M_ONE,  32'h0000_001F, 11, 64'h0000_0000_0000_0303};
      vecs[2] = '{1'b0, 5'd0,  32'hDEAD_BEEF, M_LOOP, 32'hDEAD_BEEF, 37, 64'h0000_000C_0000_0001};
      vecs[3] = '{1'b0, 5'd1,  32'h0000_0001, M_LOOP, 32'h0000_0001, 6,  64'h0000_0000_0000_0019};
      vecs[4] = '{1'b1, 5'd1,  32'h0000_0000, M_ONE,  32'h0000_0001, 7,  64'h0000_0000_0000_0033};
      vecs[5] = '{1'b0, 5'd16, 32'h1234_ABCD, M_BYP,  32'h0000_579A, 21, 64'h0000_0000_000C_0001};
      vecs[6] = '{1'b1, 5'd0,  32'h8000_0001, M_LOOP, 32'h8000_0001, 38, 64'h0000_0018_0000_0003};

      // Reset values
      repeat (3) @(posedge sysclk);
      @(negedge sysclk);
      check("rst_tck", tck, 0);
      check("rst_tms", tms, 1);
      check("rst_tdi", tdi, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_busy", busy, 1);
      check_init("pwr");

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Response held off for 50 cycles while another command is offered
      tdo_mode  = M_LOOP;
      cmd_ir    = 1'b0;
      cmd_len   = 5'd4;
      cmd_data  = 32'h5;
      cmd_valid = 1'b1;
      cyc = 0;
      while (cyc < 50 && cmd_ready !== 1'b1) begin
         @(negedge sysclk);
         cyc = cyc + 1;
      end
      @(negedge sysclk);
      cmd_valid = 1'b0;
      cyc = 0;
      while (cyc < 5000 && rsp_valid !== 1'b1) begin
         @(negedge sysclk);
         cyc = cyc + 1;
      end
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, 32'h5);
      cmd_valid = 1'b1;
      cmd_len   = 5'd8;
      cmd_data  = 32'hFFFF_FFFF;
      base = rise_cnt;
      bad  = 0;
      repeat (50) begin
         @(negedge sysclk);
         if (rsp_valid !== 1'b1 || rsp_data !== 32'h5 || cmd_ready !== 1'b0 || busy !== 1'b1) bad = bad + 1;
      end
      check("hold_stable_cycles_bad", bad, 0);
      check("hold_no_new_scan", rise_cnt - base, 0);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge sysclk);
      rsp_ready = 1'b0;
      check("hold_release_valid", rsp_valid, 0);
      check("hold_release_ready", cmd_ready, 1);
      rsp_ready = 1'b1;
      repeat (2) @(negedge sysclk);
      rsp_ready = 1'b0;
      check("idle_rsp_ready_ignored", {rsp_valid, busy, cmd_ready}, 3'b001);

      // Reset during shift bit 3 of a 16-bit DR scan
      tdo_mode  = M_BYP;
      cmd_ir    = 1'b0;
      cmd_len   = 5'd16;
      cmd_data  = 32'h0000_FFFF;
      cmd_valid = 1'b1;
      cyc = 0;
      while (cyc < 50 && cmd_ready !== 1'b1) begin
         @(negedge sysclk);
         cyc = cyc + 1;
      end
      base = rise_cnt;
      @(negedge sysclk);
      cmd_valid = 1'b0;
      cyc = 0;
      while (cyc < 500 && (rise_cnt - base) < 7) begin
         @(negedge sysclk);
         cyc = cyc + 1;
      end
      check("mid_bit3_reached", rise_cnt - base, 7);
      sys_reset = 1'b1;
      @(negedge sysclk);
      check("mid_tck", tck, 0);
      check("mid_tms", tms, 1);
      check("mid_rsp_valid", rsp_valid, 0);
      check("mid_rsp_data", rsp_data, 0);
      check("mid_busy", busy, 1);
      check("mid_cmd_ready", cmd_ready, 0);
      check_init("mid");
      run_vec(vecs[5], "post_rst");

      check("tck_shape_violations", mon_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
